// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the dynamic branch predictor:
//   - 2-bit saturating counter encodings
//   - saturating next-counter function
//   - BTB entry layout and its reset value
// The tag field is sized for the smallest legal table (4 entries, 28-bit tag
// zero-extended to 30 bits) so one struct serves every ENTRIES setting; the
// unused upper tag bits are always written as zero.
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_RESET_ENTRY = '{
        valid:  1'b0,
        tag:    '0,
        target: 32'h0,
        ctr:    CTR_WEAK_NT
    };

    // Move the counter one step toward the observed direction, holding at the
    // strong ends instead of wrapping.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_STRONG_T) ? ctr : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped storage for the predictor entries.
// Ports:
//   clk, rst       clock and asynchronous active-high reset (clears all entries)
//   i_if_idx       IF lookup index           -> o_if_entry (asynchronous read)
//   i_ex_idx       EX lookup/update index    -> o_ex_entry (asynchronous read)
//   i_wr_en        write i_wr_entry at i_ex_idx on the next rising edge
//   i_wr_entry     entry contents to write
// Reads return the stored contents; a write in the same cycle is not
// forwarded to either read port.
// -----------------------------------------------------------------------------
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_if_idx,
    output btb_entry_t            o_if_entry,
    input  logic [INDEX_BITS-1:0] i_ex_idx,
    output btb_entry_t            o_ex_entry,
    input  logic                  i_wr_en,
    input  btb_entry_t            i_wr_entry
);

    btb_entry_t r_mem [ENTRIES];

    assign o_if_entry = r_mem[i_if_idx];
    assign o_ex_entry = r_mem[i_ex_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= BTB_RESET_ENTRY;
            end
        end else if (i_wr_en) begin
            r_mem[i_ex_idx] <= i_wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// IF-stage BTB lookup with 2-bit counters, EX-stage mispredict detection and
// redirect, table training and branch/mispredict statistics.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fetch_pc                 IF PC -> predict_taken / predict_target (comb.)
//   ex_branch_valid          conditional branch resolving in EX
//   ex_jump_valid            JAL/JALR resolving in EX (wins over branch)
//   ex_pc, ex_target         PC and computed target of the EX instruction
//   ex_branch_condition_met  branch comparison result
//   ex_predicted_taken/_target  prediction carried down from IF
//   ex_stall                 EX frozen: no redirect, training or counting
//   redirect_valid/_pc       combinational flush request and corrected PC
//   branch_count             resolved branches and jumps (wraps)
//   mispredict_count         redirects issued (wraps)
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        ex_branch_valid,
    input  logic        ex_jump_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_branch_condition_met,
    input  logic        ex_predicted_taken,
    input  logic [31:0] ex_predicted_target,
    input  logic        ex_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [TAG_MAX_W-1:0]  w_if_tag;
    logic [TAG_MAX_W-1:0]  w_ex_tag;
    btb_entry_t            w_if_entry;
    btb_entry_t            w_ex_entry;
    btb_entry_t            w_wr_entry;
    logic                  w_wr_en;
    logic                  w_if_hit;
    logic                  w_ex_hit;
    logic                  w_res;
    logic                  w_actual_taken;
    logic                  w_mispredict;
    logic                  w_unused_pc_lsbs;

    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    // Instructions are word aligned, so the two PC LSBs carry no information.
    assign w_unused_pc_lsbs = ^{fetch_pc[1:0], ex_pc[1:0]};

    assign w_if_idx = fetch_pc[INDEX_BITS+1:2];
    assign w_ex_idx = ex_pc[INDEX_BITS+1:2];
    // Tags are zero-extended into the fixed-width tag field of the entry.
    assign w_if_tag = {{INDEX_BITS{1'b0}}, fetch_pc[31:INDEX_BITS+2]};
    assign w_ex_tag = {{INDEX_BITS{1'b0}}, ex_pc[31:INDEX_BITS+2]};

    branch_target_buffer #(
        .ENTRIES    (ENTRIES),
        .INDEX_BITS (INDEX_BITS)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .i_if_idx   (w_if_idx),
        .o_if_entry (w_if_entry),
        .i_ex_idx   (w_ex_idx),
        .o_ex_entry (w_ex_entry),
        .i_wr_en    (w_wr_en),
        .i_wr_entry (w_wr_entry)
    );

    // IF prediction
    assign w_if_hit       = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign predict_taken  = w_if_hit && w_if_entry.ctr[1];
    assign predict_target = predict_taken ? w_if_entry.target : 32'h0;

    // EX resolution; a jump overrides a simultaneous branch flag.
    assign w_res          = (ex_branch_valid || ex_jump_valid) && !ex_stall;
    assign w_actual_taken = ex_jump_valid || ex_branch_condition_met;

    // Held low while reset is asserted so the core never sees a redirect
    // during reset, whatever the EX inputs happen to be.
    assign w_mispredict = w_res && !rst &&
                          ((w_actual_taken != ex_predicted_taken) ||
                           (w_actual_taken && (ex_predicted_target != ex_target)));

    assign redirect_valid = w_mispredict;
    assign redirect_pc    = !w_mispredict   ? 32'h0 :
                            w_actual_taken  ? ex_target :
                                              ex_pc + 32'd4;

    // Training
    assign w_ex_hit = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_ex_entry;
        if (w_res) begin
            if (ex_jump_valid) begin
                w_wr_en    = 1'b1;
                w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, target: ex_target,
                               ctr: CTR_STRONG_T};
            end else if (ex_branch_condition_met) begin
                w_wr_en = 1'b1;
                if (w_ex_hit) begin
                    w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, target: ex_target,
                                   ctr: ctr_next(w_ex_entry.ctr, 1'b1)};
                end else begin
                    // Fresh allocation starts weakly taken so a single
                    // not-taken outcome flips it back.
                    w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, target: ex_target,
                                   ctr: CTR_WEAK_T};
                end
            end else if (w_ex_hit) begin
                // Not-taken hit only weakens the counter; a not-taken miss
                // leaves whatever entry occupies the slot untouched.
                w_wr_en        = 1'b1;
                w_wr_entry.ctr = ctr_next(w_ex_entry.ctr, 1'b0);
            end
        end
    end

    // Statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count     <= 32'h0;
            r_mispredict_count <= 32'h0;
        end else begin
            if (w_res) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        ex_branch_valid;
    logic        ex_jump_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_branch_condition_met;
    logic        ex_predicted_taken;
    logic [31:0] ex_predicted_target;
    logic        ex_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_bc = 0;
    logic [31:0] exp_mc = 0;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .fetch_pc                (fetch_pc),
        .predict_taken           (predict_taken),
        .predict_target          (predict_target),
        .ex_branch_valid         (ex_branch_valid),
        .ex_jump_valid           (ex_jump_valid),
        .ex_pc                   (ex_pc),
        .ex_target               (ex_target),
        .ex_branch_condition_met (ex_branch_condition_met),
        .ex_predicted_taken      (ex_predicted_taken),
        .ex_predicted_target     (ex_predicted_target),
        .ex_stall                (ex_stall),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .branch_count            (branch_count),
        .mispredict_count        (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ex_branch_valid         = 1'b0;
        ex_jump_valid           = 1'b0;
        ex_pc                   = 32'h0;
        ex_target               = 32'h0;
        ex_branch_condition_met = 1'b0;
        ex_predicted_taken      = 1'b0;
        ex_predicted_target     = 32'h0;
        ex_stall                = 1'b0;
    endtask

    // Drive one EX instruction and queue the redirect it must produce.
    task automatic drive_ex(input logic br, input logic jmp, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic cond, input logic pt,
                            input logic [31:0] ptgt, input logic stall,
                            input logic erv, input logic [31:0] erpc);
        exp_t e;
        ex_branch_valid         = br;
        ex_jump_valid           = jmp;
        ex_pc                   = pc;
        ex_target               = tgt;
        ex_branch_condition_met = cond;
        ex_predicted_taken      = pt;
        ex_predicted_target     = ptgt;
        ex_stall                = stall;
        e.rv  = erv;
        e.rpc = erpc;
        q.push_back(e);
        if (!stall && (br || jmp)) exp_bc = exp_bc + 1;
        if (erv) exp_mc = exp_mc + 1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        fetch_pc = 32'h100;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL reset_predict_taken got %0b want 0", predict_taken); end
        checks++;
        if (predict_target !== 32'h0) begin errors++; $display("FAIL reset_predict_target got %h want 0", predict_target); end
        checks++;
        if ({redirect_valid, redirect_pc} !== 33'h0) begin errors++; $display("FAIL reset_redirect got %0b/%h want 0/0", redirect_valid, redirect_pc); end
        checks++;
        if ({branch_count, mispredict_count} !== 64'h0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", branch_count, mispredict_count); end
    endtask

    task automatic test_first_taken();
        exp_t e;
        @(negedge clk);
        fetch_pc = 32'h100;
        drive_ex(1, 0, 32'h100, 32'h80, 1, 0, 32'h0, 0, 1, 32'h80);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL first_taken_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL no_bypass got %0b want 0", predict_taken); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h80}) begin errors++; $display("FAIL first_taken_predict got %0b/%h want 1/00000080", predict_taken, predict_target); end
        checks++;
        if ({branch_count, mispredict_count} !== {exp_bc, exp_mc}) begin errors++; $display("FAIL first_taken_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    endtask

    // Walk the counter at 0x100 down, back up, saturate high, retarget.
    typedef struct {
        logic        cond;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        erv;
        logic [31:0] erpc;
        logic        apred;
        logic [31:0] atgt;
    } row_t;

    task automatic test_counter();
        row_t rows[7];
        exp_t e;
        rows[0] = '{1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104, 1'b0, 32'h0};
        rows[1] = '{1'b0, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        rows[2] = '{1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0};
        rows[3] = '{1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80};
        rows[4] = '{1'b1, 32'h200, 1'b1, 32'h80,  1'b1, 32'h200, 1'b1, 32'h200};
        rows[5] = '{1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h200};
        rows[6] = '{1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h200};
        fetch_pc = 32'h100;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_ex(1, 0, 32'h100, rows[i].tgt, rows[i].cond, rows[i].pt, rows[i].ptgt, 0,
                     rows[i].erv, rows[i].erpc);
            #1;
            e = q.pop_front();
            checks++;
            if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL counter_redirect[%0d] got %0b/%h want %0b/%h", i, redirect_valid, redirect_pc, e.rv, e.rpc); end
            @(negedge clk);
            idle();
            #1;
            checks++;
            if ({predict_taken, predict_target} !== {rows[i].apred, rows[i].atgt}) begin errors++; $display("FAIL counter_predict[%0d] got %0b/%h want %0b/%h", i, predict_taken, predict_target, rows[i].apred, rows[i].atgt); end
        end
        checks++;
        if ({branch_count, mispredict_count} !== {exp_bc, exp_mc}) begin errors++; $display("FAIL counter_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    endtask

    task automatic test_wrap();
        exp_t e;
        @(negedge clk);
        fetch_pc = 32'hFFFF_FFFC;
        drive_ex(0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL jal_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h0}) begin errors++; $display("FAIL jal_predict got %0b/%h want 1/00000000", predict_taken, predict_target); end
        @(negedge clk);
        drive_ex(1, 0, 32'hFFFF_FFFC, 32'h10, 0, 1, 32'h0, 0, 1, 32'h0);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL pc_wrap_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_after_nt_predict got %0b/%h want 1/00000000", predict_taken, predict_target); end
        checks++;
        if ({branch_count, mispredict_count} !== {exp_bc, exp_mc}) begin errors++; $display("FAIL wrap_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    endtask

    task automatic test_stall();
        exp_t e;
        fetch_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_ex(1, 0, 32'h300, 32'h400, 1, 0, 32'h0, 1, 0, 32'h0);
            #1;
            e = q.pop_front();
            checks++;
            if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL stall_redirect[%0d] got %0b/%h want %0b/%h", i, redirect_valid, redirect_pc, e.rv, e.rpc); end
            checks++;
            if ({branch_count, mispredict_count, predict_taken} !== {exp_bc, exp_mc, 1'b0}) begin errors++; $display("FAIL stall_frozen[%0d] got %0d/%0d/%0b want %0d/%0d/0", i, branch_count, mispredict_count, predict_taken, exp_bc, exp_mc); end
        end
        @(negedge clk);
        drive_ex(1, 0, 32'h300, 32'h400, 1, 0, 32'h0, 0, 1, 32'h400);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL stall_release_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({branch_count, mispredict_count} !== {exp_bc, exp_mc}) begin errors++; $display("FAIL stall_release_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h400}) begin errors++; $display("FAIL stall_release_predict got %0b/%h want 1/00000400", predict_taken, predict_target); end
    endtask

    task automatic test_alias();
        exp_t        e;
        logic [31:0] alias_pc;
        alias_pc = 32'h100 + 4 * ENTRIES;
        @(negedge clk);
        drive_ex(0, 1, 32'h100, 32'h180, 0, 1, 32'h200, 0, 1, 32'h180);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL alias_jump_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        fetch_pc = alias_pc;
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b0, 32'h0}) begin errors++; $display("FAIL alias_tag_miss got %0b/%h want 0/00000000", predict_taken, predict_target); end
        // Not-taken miss at the alias must leave the resident entry alone.
        drive_ex(1, 0, alias_pc, 32'h900, 0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL alias_nt_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        fetch_pc = 32'h100;
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h180}) begin errors++; $display("FAIL alias_resident_kept got %0b/%h want 1/00000180", predict_taken, predict_target); end
        // Taken miss at the alias replaces the resident entry.
        drive_ex(1, 0, alias_pc, 32'h900, 1, 0, 32'h0, 0, 1, 32'h900);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL alias_alloc_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted got %0b want 0", predict_taken); end
        fetch_pc = alias_pc;
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h900}) begin errors++; $display("FAIL alias_alloc_predict got %0b/%h want 1/00000900", predict_taken, predict_target); end
    endtask

    task automatic test_both_valid();
        exp_t e;
        fetch_pc = 32'h600;
        @(negedge clk);
        drive_ex(1, 1, 32'h600, 32'h640, 0, 0, 32'h0, 0, 1, 32'h640);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL both_valid_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        drive_ex(1, 0, 32'h600, 32'h640, 0, 1, 32'h640, 0, 1, 32'h604);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL both_valid_nt_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b1, 32'h640}) begin errors++; $display("FAIL both_valid_strong got %0b/%h want 1/00000640", predict_taken, predict_target); end
        checks++;
        if ({branch_count, mispredict_count} !== {exp_bc, exp_mc}) begin errors++; $display("FAIL both_valid_counts got %0d/%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        fetch_pc = 32'h700;
        @(negedge clk);
        drive_ex(1, 0, 32'h700, 32'h740, 1, 0, 32'h0, 0, 1, 32'h740);
        #1;
        e = q.pop_front();
        checks++;
        if ({redirect_valid, redirect_pc} !== {e.rv, e.rpc}) begin errors++; $display("FAIL mid_reset_pre_redirect got %0b/%h want %0b/%h", redirect_valid, redirect_pc, e.rv, e.rpc); end
        #1;
        rst    = 1'b1;
        exp_bc = 0;
        exp_mc = 0;
        #1;
        checks++;
        if ({redirect_valid, redirect_pc} !== 33'h0) begin errors++; $display("FAIL mid_reset_redirect got %0b/%h want 0/00000000", redirect_valid, redirect_pc); end
        checks++;
        if ({branch_count, mispredict_count} !== {exp_bc, exp_mc}) begin errors++; $display("FAIL mid_reset_counts got %0d/%0d want 0/0", branch_count, mispredict_count); end
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if ({predict_taken, predict_target} !== {1'b0, 32'h0}) begin errors++; $display("FAIL mid_reset_no_write got %0b/%h want 0/00000000", predict_taken, predict_target); end
        fetch_pc = 32'h100;
        #1;
        checks++;
        if (predict_taken !== 1'b0) begin errors++; $display("FAIL mid_reset_table_clear got %0b want 0", predict_taken); end
        checks++;
        if ({branch_count, mispredict_count} !== 64'h0) begin errors++; $display("FAIL mid_reset_counts_after got %0d/%0d want 0/0", branch_count, mispredict_count); end
    endtask

    initial begin
        test_reset();
        test_first_taken();
        test_counter();
        test_wrap();
        test_stall();
        test_alias();
        test_both_valid();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
